// File: rtl/xc_malu_mp_pkg.sv
// Shared definitions for the multi-precision MALU sequencer: op codes,
// FSM state encoding and small decode helpers.
package xc_malu_mp_pkg;

    localparam logic [1:0] OP_MADD = 2'b00;
    localparam logic [1:0] OP_MSUB = 2'b01;
    localparam logic [1:0] OP_MMAC = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LIMB = 3'd1,
        ST_MUL       = 3'd2,
        ST_EMIT      = 3'd3,
        ST_EMIT_HI   = 3'd4
    } state_e;

    // The reserved encoding is folded onto MADD at request time so the
    // datapath only ever sees three ops.
    function automatic logic [1:0] canon_op(input logic [1:0] op);
        return (op == OP_RSVD) ? OP_MADD : op;
    endfunction

endpackage

// File: rtl/xc_malu_mp_mul.sv
// Bit-serial XLEN x XLEN shift-add multiplier with a preloaded addend.
// One multiplier bit per cycle, LSB first; done marks the final step.
module xc_malu_mp_mul
    import xc_malu_mp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   s,
    input  logic [2*XLEN-1:0] addend,
    output logic              done,
    output logic [2*XLEN-1:0] product
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] a_sh_q, a_sh_d;
    logic [XLEN-1:0]   s_q, s_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              run_q, run_d;

    // Shifting a and s instead of indexing by count keeps the adder input
    // free of a barrel shifter.
    always_comb begin
        acc_d   = acc_q;
        a_sh_d  = a_sh_q;
        s_d     = s_q;
        count_d = count_q;
        run_d   = run_q;
        if (start) begin
            acc_d   = addend;
            a_sh_d  = {{XLEN{1'b0}}, a};
            s_d     = s;
            count_d = '0;
            run_d   = 1'b1;
        end else if (run_q) begin
            if (s_q[0]) begin
                acc_d = acc_q + a_sh_q;
            end
            a_sh_d  = a_sh_q << 1;
            s_d     = s_q >> 1;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_CNT) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            acc_q   <= '0;
            a_sh_q  <= '0;
            s_q     <= '0;
            count_q <= '0;
            run_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            a_sh_q  <= a_sh_d;
            s_q     <= s_d;
            count_q <= count_d;
            run_q   <= run_d;
        end
    end

    assign done    = run_q && (count_q == LAST_CNT);
    assign product = acc_d;

endmodule

// File: rtl/xc_malu_mp.sv
// Multi-precision add / subtract / multiply-accumulate sequencer. Limbs
// stream in LS-first; carry, borrow or high word is chained internally.
module xc_malu_mp
    import xc_malu_mp_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_cin,
    input  logic [XLEN-1:0] req_scalar,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [XLEN-1:0] in_c,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_last,
    output logic            out_carry,
    output logic            busy
);

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   scalar_q, scalar_d;
    logic              cy_q, cy_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   r_q, r_d;
    logic              last_q, last_d;

    logic [XLEN:0]     sum;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] mul_addend;
    logic              mul_start;
    logic              mul_done;
    logic [2*XLEN-1:0] mul_product;

    assign sum  = {1'b0, in_a} + {1'b0, in_b} + {{XLEN{1'b0}}, cy_q};
    // The top bit of the widened difference is the outgoing borrow.
    assign diff = {1'b0, in_a} - {1'b0, in_b} - {{XLEN{1'b0}}, cy_q};
    assign mul_addend = {{(XLEN-1){1'b0}}, ({1'b0, in_c} + {1'b0, hi_q})};

    xc_malu_mp_mul #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (g_clk),
        .srst    (g_reset),
        .start   (mul_start),
        .a       (in_a),
        .s       (scalar_q),
        .addend  (mul_addend),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        scalar_d  = scalar_q;
        cy_d      = cy_q;
        hi_d      = hi_q;
        r_d       = r_q;
        last_d    = last_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d     = canon_op(req_op);
                    scalar_d = req_scalar;
                    cy_d     = (canon_op(req_op) == OP_MMAC) ? 1'b0 : req_cin;
                    hi_d     = '0;
                    state_d  = ST_WAIT_LIMB;
                end
            end
            ST_WAIT_LIMB: begin
                if (in_valid) begin
                    last_d = in_last;
                    case (op_q)
                        OP_MSUB: begin
                            r_d     = diff[XLEN-1:0];
                            cy_d    = diff[XLEN];
                            state_d = ST_EMIT;
                        end
                        OP_MMAC: begin
                            mul_start = 1'b1;
                            state_d   = ST_MUL;
                        end
                        default: begin
                            r_d     = sum[XLEN-1:0];
                            cy_d    = sum[XLEN];
                            state_d = ST_EMIT;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    r_d     = mul_product[XLEN-1:0];
                    hi_d    = mul_product[2*XLEN-1:XLEN];
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (!last_q) begin
                        state_d = ST_WAIT_LIMB;
                    end else if (op_q == OP_MMAC) begin
                        state_d = ST_EMIT_HI;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_EMIT_HI: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MADD;
            scalar_q <= '0;
            cy_q     <= 1'b0;
            hi_q     <= '0;
            r_q      <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            scalar_q <= scalar_d;
            cy_q     <= cy_d;
            hi_q     <= hi_d;
            r_q      <= r_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        in_ready  = (state_q == ST_WAIT_LIMB);
        out_valid = (state_q == ST_EMIT) || (state_q == ST_EMIT_HI);
        busy      = (state_q != ST_IDLE);
        out_data  = '0;
        out_last  = 1'b0;
        out_carry = 1'b0;
        if (state_q == ST_EMIT) begin
            out_data  = r_q;
            out_last  = last_q && (op_q != OP_MMAC);
            out_carry = last_q && (op_q != OP_MMAC) && cy_q;
        end else if (state_q == ST_EMIT_HI) begin
            out_data  = hi_q;
            out_last  = 1'b1;
        end
    end

endmodule

// File: doc/xc_malu_mp.md
# xc_malu_mp

Parametrised multi-precision arithmetic sequencer for the XCrypto MALU. It processes full N-limb operands, where the existing MALU long-op path handles one word-sized atomic step per instruction. Operand limbs stream in least-significant limb first, and the carry, borrow or high-word chaining between limbs is kept in internal state. Result limbs stream out, so software-visible multi-limb add, subtract and multiply-accumulate need no per-limb instruction sequence.

## Interface
Reset is synchronous and active-high. One clock.

Parameters:
- XLEN, 32, limb width in bits (≥8, power of two)
- CNT_W, $clog2(XLEN)+1, width of the internal multiply step counter

Ports:
- g_clk  in  1  clock; all state updates on rising edge
- g_reset  in  1  synchronous active-high reset
- req_valid  in  1  operation request
- req_ready  out  1  high only in IDLE
- req_op  in  2  00 MADD, 01 MSUB, 10 MMAC, 11 reserved (treated as MADD)
- req_cin  in  1  initial carry (MADD) or borrow (MSUB); ignored for MMAC
- req_scalar  in  XLEN  MMAC multiplier s
- in_valid  in  1  operand limb valid
- in_ready  out  1  high only in WAIT_LIMB
- in_a, in_b, in_c  in  XLEN each  operand limbs; in_c used only by MMAC
- in_last  in  1  marks the most-significant limb
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accept
- out_data  out  XLEN  result limb
- out_last  out  1  final beat of the operation
- out_carry  out  1  final carry/borrow; meaningful only with out_last (0 for MMAC)
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, WAIT_LIMB, MUL, EMIT, EMIT_HI.
- IDLE
  - On req_valid, latch op, scalar and chain register: cy = req_cin, hi = 0.
  - Go to WAIT_LIMB.
- WAIT_LIMB
  - On in_valid, latch the limb and last flag.
  - MADD: {cy, r} ← a + b + cy. Go to EMIT.
  - MSUB: {bw, r} ← a − b − bw, where bw = 1 on underflow. Go to EMIT.
  - MMAC: load the multiplier with acc = c + hi and count = 0. Go to MUL.
- MUL
  - Bit-serial shift-add, one bit of s per cycle, LSB first: acc += (a << count) if s[count].
  - Exit after exactly XLEN cycles.
  - r = acc[XLEN-1:0]; hi = acc[2XLEN-1:XLEN]. Go to EMIT.
  - Width rule: a·s + c + hi ≤ 2^(2·XLEN) − 1, so there is never overflow.
- EMIT
  - Hold out_valid with stable data until out_ready.
  - On handshake:
    - if not last: go to WAIT_LIMB;
    - if last and op = MMAC: go to EMIT_HI;
    - otherwise: go to IDLE.
  - out_last = last && op ≠ MMAC; out_carry = cy/bw on that beat.
- EMIT_HI
  - out_data = hi, out_last = 1, out_carry = 0.
  - On handshake, go to IDLE.
- Single-limb operation (in_last on first limb) is legal.
- Scalar 0 gives result limbs = c + hi chain only; the MUL state still takes XLEN cycles.
- Reserved op 11 behaves as MADD.
- Reset at any point, including mid-MUL or mid-EMIT:
  - next state IDLE; all outputs 0 except req_ready = 1;
  - cy, hi, acc and count cleared; the partial operation is discarded.

## Timing
- Outputs after reset: req_ready 1; in_ready, out_valid, out_data, out_last, out_carry and busy all 0.
- Request accepted at cycle t → in_ready at t+1.
- MADD/MSUB:
  - limb accepted at t → out_valid at t+1;
  - with out_ready high, the next in_ready is at t+2;
  - throughput is one limb per 2 cycles.
- MMAC:
  - limb accepted at t → out_valid at t+XLEN+1;
  - EMIT_HI beat appears the cycle after the last limb's handshake.
- in_ready and out_valid are never high in the same cycle.
- req_ready is low from acceptance until the cycle after the final handshake.

## Structure
- Package xc_malu_mp_pkg:
  - op encodings (OP_MADD, OP_MSUB, OP_MMAC);
  - state enumeration and widths.
- Sub-module xc_malu_mp_mul:
  - bit-serial XLEN×XLEN shift-add multiplier with preloaded addend;
  - ports: start, a, s, addend → done, 2·XLEN product.
- Top level holds the FSM, chain registers and handshakes.

## Test plan
- MADD, XLEN=32, cin=0, a={0xFFFFFFFF, 0x00000001}, b={0x00000001, 0x00000000} → out {0x00000000, 0x00000002}, out_carry=0 on the last beat, each beat 1 cycle after its limb handshake.
- MSUB single limb, a=0x0, b=0x1, cin=0 → out_data 0xFFFFFFFF, out_last=1, out_carry=1.
- MMAC, s=0xFFFFFFFF, a={0xFFFFFFFF}, c={0xFFFFFFFF} → beat 0x00000000 (out_last=0) at t+33, then hi beat 0xFFFFFFFF with out_last=1, out_carry=0.
- out_ready held low 5 cycles in EMIT → out_data/out_last stable, in_ready=0, req_ready=0; completion on release.
- g_reset asserted in MUL at count=10 → next cycle: busy=0, out_valid=0, req_ready=1; a new MADD 1+1 then yields 0x2.
- XLEN=8: MADD a=0xFF, b=0x01, cin=1 → out_data 0x01, out_carry=1; MMAC s=0xFF, a=0xFF, c=0xFF → 0x00 then hi 0xFF.
